// File: rtl/hand_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hand_filter_pkg
// Description : Shared types and helpers for the hand position filter.
// Revision    : 1.0 - initial release
// ============================================================================
package hand_filter_pkg;

    typedef logic [11:0] coord_t;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } filt_state_t;

    typedef enum logic [1:0] {
        GATE_SEED   = 2'd0,
        GATE_ACCEPT = 2'd1,
        GATE_REJECT = 2'd2
    } gate_t;

    // Unsigned distance between two coordinates, one bit wider than a coordinate
    function automatic logic [12:0] abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_average.sv
`default_nettype none
// ============================================================================
// Module      : axis_average
// Description : One-axis moving average: sample history plus running sum.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_average
    import hand_filter_pkg::*;
#(
    parameter int LOG2_DEPTH = 2
) (
    input  logic   clk_in,
    input  logic   rst_in_n,
    input  logic   seed,
    input  logic   accept,
    input  coord_t sample,
    output coord_t average
);

    localparam int c_DEPTH = 1 << LOG2_DEPTH;
    localparam int c_SUM_W = 12 + LOG2_DEPTH;

    coord_t               r_hist [c_DEPTH];
    logic [c_SUM_W-1:0]   r_sum;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_sum <= '0;
        end else if (seed) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_hist[i] <= sample;
            end
            r_sum <= {sample, {LOG2_DEPTH{1'b0}}};
        end else if (accept) begin
            // Sum always contains the oldest slot, so the subtraction cannot underflow
            r_sum <= r_sum - c_SUM_W'(r_hist[c_DEPTH-1]) + c_SUM_W'(sample);
            for (int i = c_DEPTH - 1; i > 0; i--) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_hist[0] <= sample;
        end
    end

    assign average = r_sum[c_SUM_W-1:LOG2_DEPTH];

endmodule
`default_nettype wire

// File: rtl/hand_position_filter.sv
`default_nettype none
// ============================================================================
// Module      : hand_position_filter
// Description : Outlier gate, moving average and lock tracking for the hand centroid.
// Revision    : 1.0 - initial release
// ============================================================================
module hand_position_filter
    import hand_filter_pkg::*;
#(
    parameter int LOG2_DEPTH     = 2,
    parameter int JUMP_THRESH    = 200,
    parameter int MAX_REJECT     = 3,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        frame_tick_in,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [11:0] x_in,
    input  logic [11:0] y_in,
    output logic        valid_out,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic        locked_out,
    output logic [2:0]  reject_count_out
);

    localparam int          c_MISS_W    = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [12:0] c_THRESH    = 13'(JUMP_THRESH);
    localparam logic [2:0]  c_MAX_REJ   = 3'(MAX_REJECT);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(TIMEOUT_FRAMES - 1);

    logic          r_s1, r_s2, r_s3;
    coord_t        r_x_q, r_y_q;
    logic [12:0]   r_dx, r_dy;
    gate_t         r_gate, w_gate;
    filt_state_t   r_state, w_state_next;
    logic [2:0]    r_reject, w_reject_next;
    logic [c_MISS_W-1:0] r_miss, w_miss_next;
    coord_t        r_x_out, r_y_out;
    logic          r_valid;
    logic          w_take, w_seed, w_accept, w_reject;
    coord_t        w_x_avg, w_y_avg;

    assign ready_out = ~(r_s1 | r_s2 | r_s3);
    assign w_take    = valid_in & ready_out;

    always_comb begin
        w_gate = GATE_SEED;
        if (r_state == LOCKED) begin
            if (r_dx <= c_THRESH && r_dy <= c_THRESH) begin
                w_gate = GATE_ACCEPT;
            end else if (r_reject < c_MAX_REJ) begin
                w_gate = GATE_REJECT;
            end
        end
    end

    assign w_seed   = r_s2 && (w_gate == GATE_SEED);
    assign w_accept = r_s2 && (w_gate == GATE_ACCEPT);
    assign w_reject = r_s2 && (w_gate == GATE_REJECT);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state  <= UNLOCKED;
            r_reject <= '0;
            r_miss   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_reject <= w_reject_next;
            r_miss   <= w_miss_next;
        end
    end

    // A seed/accept clears the miss counter and swallows a coincident frame tick
    always_comb begin
        w_state_next  = r_state;
        w_reject_next = r_reject;
        w_miss_next   = r_miss;
        if (w_seed || w_accept) begin
            w_reject_next = '0;
            w_miss_next   = '0;
            if (w_seed) begin
                w_state_next = LOCKED;
            end
        end else begin
            if (w_reject) begin
                w_reject_next = r_reject + 3'd1;
            end
            if (frame_tick_in && (r_state == LOCKED)) begin
                if (r_miss == c_MISS_LAST) begin
                    w_state_next  = UNLOCKED;
                    w_miss_next   = '0;
                    w_reject_next = '0;
                end else begin
                    w_miss_next = r_miss + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_x_q   <= '0;
            r_y_q   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_gate  <= GATE_SEED;
            r_x_out <= '0;
            r_y_out <= '0;
            r_valid <= 1'b0;
        end else begin
            r_s1    <= w_take;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= r_s3;
            if (w_take) begin
                r_x_q <= x_in;
                r_y_q <= y_in;
            end
            if (r_s1) begin
                r_dx <= abs_diff(r_x_q, r_x_out);
                r_dy <= abs_diff(r_y_q, r_y_out);
            end
            if (r_s2) begin
                r_gate <= w_gate;
            end
            if (r_s3 && (r_gate != GATE_REJECT)) begin
                r_x_out <= w_x_avg;
                r_y_out <= w_y_avg;
            end
        end
    end

    axis_average #(.LOG2_DEPTH(LOG2_DEPTH)) u_avg_x (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .seed     (w_seed),
        .accept   (w_accept),
        .sample   (r_x_q),
        .average  (w_x_avg)
    );

    axis_average #(.LOG2_DEPTH(LOG2_DEPTH)) u_avg_y (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .seed     (w_seed),
        .accept   (w_accept),
        .sample   (r_y_q),
        .average  (w_y_avg)
    );

    assign valid_out        = r_valid;
    assign x_out            = r_x_out;
    assign y_out            = r_y_out;
    assign locked_out       = (r_state == LOCKED);
    assign reject_count_out = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_hand_position_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hand_position_filter
// Description : Table-driven scoreboard bench for hand_position_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hand_position_filter;

    logic        clk_in = 1'b0;
    logic        rst_in_n;
    logic        frame_tick_in;
    logic        valid_in;
    logic        ready_out;
    logic [11:0] x_in, y_in;
    logic        valid_out;
    logic [11:0] x_out, y_out;
    logic        locked_out;
    logic [2:0]  reject_count_out;

    always #5 clk_in = ~clk_in;

    hand_position_filter dut (
        .clk_in           (clk_in),
        .rst_in_n         (rst_in_n),
        .frame_tick_in    (frame_tick_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .x_in             (x_in),
        .y_in             (y_in),
        .valid_out        (valid_out),
        .x_out            (x_out),
        .y_out            (y_out),
        .locked_out       (locked_out),
        .reject_count_out (reject_count_out)
    );

    typedef struct {
        logic [11:0] ex;
        logic [11:0] ey;
        logic        el;
        logic [2:0]  er;
    } exp_t;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        exp_t        e;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        tbl[13];
    logic [11:0] cont_exp[4];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk_e(input int ex, input int ey, input int el, input int er);
        exp_t e;
        e.ex = 12'(ex); e.ey = 12'(ey); e.el = 1'(el); e.er = 3'(er);
        return e;
    endfunction

    function automatic vec_t mk_v(input int x, input int y, input int ex, input int ey,
                                  input int el, input int er);
        vec_t v;
        v.x = 12'(x); v.y = 12'(y); v.e = mk_e(ex, ey, el, er);
        return v;
    endfunction

    // Every valid_out pulse must match the oldest outstanding expectation
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid_out", valid_out, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("x_out", x_out, mon_e.ex);
                check("y_out", y_out, mon_e.ey);
                check("locked_out", locked_out, mon_e.el);
                check("reject_count_out", reject_count_out, mon_e.er);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [11:0] x, input logic [11:0] y, input exp_t e);
        int t = 0;
        while (ready_out !== 1'b1 && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        check("ready_before_send", ready_out, 1);
        x_in = x; y_in = y; valid_in = 1'b1;
        sb_q.push_back(e);
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 20) begin
            @(negedge clk_in);
            t++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
        @(negedge clk_in);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in_n = 1'b0; frame_tick_in = 1'b0; valid_in = 1'b0; x_in = '0; y_in = '0;
        tbl[0]  = mk_v(500, 300, 500, 300, 1, 0);
        tbl[1]  = mk_v(504, 300, 501, 300, 1, 0);
        tbl[2]  = mk_v(508, 300, 503, 300, 1, 0);
        tbl[3]  = mk_v(512, 300, 506, 300, 1, 0);
        tbl[4]  = mk_v(516, 300, 510, 300, 1, 0);
        tbl[5]  = mk_v(900, 300, 510, 300, 1, 1);
        tbl[6]  = mk_v(512, 300, 512, 300, 1, 0);
        tbl[7]  = mk_v(900, 300, 512, 300, 1, 1);
        tbl[8]  = mk_v(900, 300, 512, 300, 1, 2);
        tbl[9]  = mk_v(900, 300, 512, 300, 1, 3);
        tbl[10] = mk_v(900, 300, 900, 300, 1, 0);
        tbl[11] = mk_v(900, 600, 900, 300, 1, 1);
        tbl[12] = mk_v(950, 350, 912, 312, 1, 0);
        cont_exp[0] = 12'd100; cont_exp[1] = 12'd101;
        cont_exp[2] = 12'd101; cont_exp[3] = 12'd102;

        repeat (3) @(negedge clk_in);
        rst_in_n = 1'b1;
        @(negedge clk_in);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_locked_out", locked_out, 0);
        check("rst_reject_count", reject_count_out, 0);
        check("rst_ready_out", ready_out, 1);

        for (int i = 0; i < 13; i++) begin
            send(tbl[i].x, tbl[i].y, tbl[i].e);
            if (i == 0) begin
                repeat (2) @(negedge clk_in);
                check("latency_early", valid_out, 0);
                @(negedge clk_in);
                check("latency_pulse", valid_out, 1);
            end
            drain();
        end

        // Outlier leaves a nonzero reject count, then the timeout must clear it
        send(12'd3000, 12'd312, mk_e(912, 312, 1, 1));
        drain();
        for (int i = 1; i <= 8; i++) begin
            frame_tick_in = 1'b1;
            @(negedge clk_in);
            frame_tick_in = 1'b0;
            @(negedge clk_in);
            if (i == 7) check("locked_before_timeout", locked_out, 1);
        end
        check("timeout_locked", locked_out, 0);
        check("timeout_reject_cleared", reject_count_out, 0);
        check("timeout_x_hold", x_out, 912);
        check("timeout_y_hold", y_out, 312);
        send(12'd100, 12'd100, mk_e(100, 100, 1, 0));
        drain();

        // Continuous valid_in: one acceptance every 4 cycles
        n_acc = 0;
        x_in = 12'd102; y_in = 12'd100; valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ready_pattern", ready_out, (i % 4 == 0) ? 1 : 0);
            if (ready_out === 1'b1) begin
                if (n_acc < 4) sb_q.push_back(mk_e(cont_exp[n_acc], 100, 1, 0));
                n_acc++;
            end
            @(negedge clk_in);
        end
        valid_in = 1'b0;
        check("continuous_accept_count", n_acc, 4);
        drain();

        // Reset at E1 discards the in-flight sample
        x_in = 12'd700; y_in = 12'd700; valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        @(posedge clk_in);
        #1 rst_in_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("reset_no_valid", valid_out, 0);
        end
        check("reset_x_out", x_out, 0);
        check("reset_y_out", y_out, 0);
        check("reset_locked", locked_out, 0);
        check("reset_reject", reject_count_out, 0);
        check("reset_ready", ready_out, 1);
        rst_in_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("post_reset_no_valid", valid_out, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hand_position_filter.md
Name: hand_position_filter

Overview:
- Sits between camera_interface and game_logic_and_renderer on the clk_65mhz domain.
- Takes the raw per-frame hand centroid (x, y) from the camera path and rejects single-frame outlier jumps.
- Smooths the accepted samples with a power-of-two moving average.
- Tracks lock/loss of the hand, so the game sees stable 12-bit coordinates plus a locked flag.

Parameters:
- LOG2_DEPTH, 2, log2 of moving-average window (window = 4 samples); legal 1..4.
- JUMP_THRESH, 200, max per-axis |sample - x_out/y_out| accepted while locked, in pixels.
- MAX_REJECT, 3, consecutive rejected samples after which the next sample is force-accepted as a re-seed.
- TIMEOUT_FRAMES, 8, frame ticks without an accepted sample before lock drops.

Ports:
- clk_in  input  1  system clock (65 MHz pixel clock).
- rst_in_n  input  1  asynchronous active-low reset.
- frame_tick_in  input  1  one-cycle pulse per video frame (vsync edge).
- valid_in  input  1  raw centroid sample present.
- ready_out  output  1  block can accept a sample this cycle.
- x_in  input  12  raw centroid x.
- y_in  input  12  raw centroid y.
- valid_out  output  1  one-cycle pulse: x_out/y_out just updated.
- x_out  output  12  filtered x.
- y_out  output  12  filtered y.
- locked_out  output  1  filter is tracking a hand.
- reject_count_out  output  3  current consecutive-reject count (debug/LEDs).

Behaviour:
- Reset (async, rst_in_n=0), all outputs and state cleared:
  - x_out = 0, y_out = 0, valid_out = 0, locked_out = 0, reject_count_out = 0, ready_out = 1.
  - History, sum and miss counter = 0; FSM = UNLOCKED.
- Handshake:
  - A sample is accepted on a rising edge with valid_in & ready_out.
  - ready_out deasserts the following cycle and stays low 3 cycles.
  - valid_in while ready_out = 0 is ignored; no buffering.
- Pipeline after acceptance edge E0:
  - E1: compute per-axis |x_in_q - x_out| and |y_in_q - y_out| (13-bit unsigned).
  - E2: gate decision; history and running sums updated.
  - E3: x_out/y_out registered, valid_out high for exactly the one cycle after E3, ready_out high again.
  - Throughput: 1 sample per 4 cycles.
- Gate decision at E2:
  - UNLOCKED: always SEED.
  - LOCKED, both axis diffs <= JUMP_THRESH: ACCEPT.
  - LOCKED, either diff > JUMP_THRESH, reject_count < MAX_REJECT: REJECT.
  - LOCKED, either diff > JUMP_THRESH, reject_count == MAX_REJECT: SEED.
- SEED:
  - All 2^LOG2_DEPTH history slots = sample; sum = sample << LOG2_DEPTH.
  - reject_count = 0, miss counter = 0, FSM -> LOCKED.
  - Output = sample exactly.
- ACCEPT:
  - sum = sum - oldest + sample, evaluated at width 12+LOG2_DEPTH with no overflow possible.
  - Shift history; reject_count = 0, miss counter = 0.
  - Output = sum >> LOG2_DEPTH, truncating.
- REJECT:
  - History and sum unchanged; reject_count += 1; miss counter not cleared.
  - valid_out still pulses, with x_out/y_out unchanged.
- FSM has two states, UNLOCKED and LOCKED; locked_out mirrors the state.
- Timeout, on each frame_tick_in while LOCKED:
  - miss counter += 1.
  - When it reaches TIMEOUT_FRAMES: FSM -> UNLOCKED, miss = 0, reject_count = 0.
  - x_out/y_out hold their last value.
- Simultaneous events:
  - frame_tick_in in the same cycle that an E2 ACCEPT/SEED clears the miss counter: the clear wins and the tick is dropped.
  - Timeout firing while a sample is in flight: the E2 decision uses the state registered at E2.
- Reset asserted mid-pipeline: in-flight sample discarded, no valid_out.

Decomposition:
- Package hand_filter_pkg holds:
  - typedef coord_t (logic [11:0]).
  - enum filt_state_t {UNLOCKED, LOCKED}.
  - enum gate_t {GATE_SEED, GATE_ACCEPT, GATE_REJECT}.
- One sub-module, axis_average: per-axis history shift register plus running sum.
  - Inputs: seed, accept, sample.
  - Output: average.
  - Instantiated twice (x, y).
- The gate/FSM/timeout logic stays in the top module.

Test Plan:
- Reset then one sample (x=500, y=300): valid_out pulses 4 cycles after the accept edge; x_out=500, y_out=300, locked_out=1.
- Locked at 500/300, then samples x=504, 508, 512, 516 (y fixed): x_out after each = 501, 503, 506, 510.
- Locked at 500, single sample x=900: REJECT, x_out stays 500, reject_count_out=1; next sample x=502 accepted, reject_count_out=0.
- Locked at 500, four consecutive samples x=900: the first three are rejected (count 1, 2, 3); the fourth seeds, so x_out=900.
- Locked, no samples, 8 frame_tick_in pulses: locked_out falls after the 8th; a next sample of 100 seeds with x_out=100 exactly.
- valid_in held high continuously: exactly one sample accepted per 4 cycles; ready_out pattern 1,0,0,0 repeats. Also assert rst_in_n low at E1: no valid_out, all outputs 0.
